// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller for the EX stage.
// Evaluates conditional branches and jumps, issues a one-cycle PC redirect,
// and squashes IF/ID for FLUSH_CYCLES cycles after every taken redirect.
// Optional build macro: BRU_PERF_CNT_EN adds the branch/taken performance
// counters. Without it, o_br_cnt and o_taken_cnt are tied to zero.
`timescale 1ns/1ps

module branch_resolve_ctrl #(
  parameter int FLUSH_CYCLES = 2   // legal range 1..3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_is_branch,
  input  logic        i_is_jump,
  input  logic [2:0]  i_br_type,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_target,
  input  logic        i_stall,
  output logic        o_br_un,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_busy,
  output logic [15:0] o_br_cnt,
  output logic [15:0] o_taken_cnt
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  // Countdown value loaded on entry to FLUSH; the last flush cycle sees zero.
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  logic        r_state;
  logic [1:0]  r_flush_cnt;
  logic        r_redirect;
  logic [31:0] r_redirect_pc;

  logic w_equal;
  logic w_less;
  logic w_br_taken;
  logic w_taken;
  logic w_accept;
  logic w_accept_taken;

  // funct3 bit 1 distinguishes the unsigned compares (BLTU/BGEU).
  assign o_br_un = i_br_type[1];

  assign w_equal = (i_rs1_data == i_rs2_data);
  assign w_less  = o_br_un ? (i_rs1_data < i_rs2_data)
                           : ($signed(i_rs1_data) < $signed(i_rs2_data));

  // Branch condition decode; funct3 010/011 are not branch encodings.
  always_comb begin
    w_br_taken = 1'b0;
    case (i_br_type)
      3'b000:  w_br_taken = w_equal;
      3'b001:  w_br_taken = !w_equal;
      3'b100:  w_br_taken = w_less;
      3'b101:  w_br_taken = !w_less;
      3'b110:  w_br_taken = w_less;
      3'b111:  w_br_taken = !w_less;
      default: w_br_taken = 1'b0;
    endcase
  end

  // Jumps always redirect, even if the branch flag is also raised.
  assign w_taken        = i_is_jump | (i_is_branch & w_br_taken);
  assign w_accept       = (r_state == ST_IDLE) & i_valid & !i_stall
                          & (i_is_branch | i_is_jump);
  assign w_accept_taken = w_accept & w_taken;

  // Control FSM: redirect pulse, held redirect address and flush countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_flush_cnt   <= 2'd0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'h0000_0000;
    end else begin
      r_redirect <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept_taken) begin
          r_state       <= ST_FLUSH;
          r_flush_cnt   <= FLUSH_LAST;
          r_redirect    <= 1'b1;
          r_redirect_pc <= {i_target[31:1], 1'b0};
        end
      end else begin
        // The countdown ignores i_stall so the squash length stays fixed.
        if (r_flush_cnt == 2'd0) begin
          r_state <= ST_IDLE;
        end else begin
          r_flush_cnt <= r_flush_cnt - 2'd1;
        end
      end
    end
  end

  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_flush       = (r_state == ST_FLUSH);
  assign o_busy        = (r_state == ST_FLUSH);

`ifdef BRU_PERF_CNT_EN
  logic [15:0] r_br_cnt;
  logic [15:0] r_taken_cnt;

  // Performance counters; a jump that also flags branch counts only as taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_cnt    <= 16'h0000;
      r_taken_cnt <= 16'h0000;
    end else begin
      if (w_accept & i_is_branch & !i_is_jump) begin
        r_br_cnt <= r_br_cnt + 16'h0001;
      end
      if (w_accept_taken) begin
        r_taken_cnt <= r_taken_cnt + 16'h0001;
      end
    end
  end

  assign o_br_cnt    = r_br_cnt;
  assign o_taken_cnt = r_taken_cnt;
`else
  assign o_br_cnt    = 16'h0000;
  assign o_taken_cnt = 16'h0000;
`endif

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of squash cycles after a redirect (legal 1..3).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  EX-stage instruction valid.
REQ-005 SHALL have port i_is_branch  input  1  EX instruction is a conditional branch.
REQ-006 SHALL have port i_is_jump  input  1  EX instruction is JAL/JALR.
REQ-007 SHALL have port i_br_type  input  3  funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-008 SHALL have ports i_rs1_data and i_rs2_data  input  32 each  compare operands.
REQ-009 SHALL have port i_target  input  32  computed branch/jump target.
REQ-010 SHALL have port i_stall  input  1  EX held by downstream stall.
REQ-011 SHALL have port o_br_un  output  1  comparator unsigned select.
REQ-012 SHALL have port o_redirect  output  1  one-cycle PC redirect pulse.
REQ-013 SHALL have port o_redirect_pc  output  32  redirect address.
REQ-014 SHALL have port o_flush  output  1  squash IF/ID.
REQ-015 SHALL have port o_busy  output  1  state not IDLE.
REQ-016 SHALL have ports o_br_cnt and o_taken_cnt  output  16 each  performance counters.

Function
REQ-017 o_br_un SHALL be combinational i_br_type[1].
REQ-018 Compare SHALL give equal = (rs1==rs2); less = signed rs1<rs2 when o_br_un=0, unsigned when 1.
REQ-019 Taken SHALL be: BEQ equal, BNE !equal, BLT/BLTU less, BGE/BGEU !less; types 010/011 never taken.
REQ-020 i_is_jump SHALL be always taken and take precedence when i_is_branch is also high.
REQ-021 Accept SHALL occur on an edge where state=IDLE, i_valid=1, i_stall=0, and (i_is_branch or i_is_jump).
REQ-022 FSM SHALL have states IDLE and FLUSH; IDLE->FLUSH on an accepted taken instruction; otherwise IDLE holds.
REQ-023 Accepted-taken at edge N SHALL drive o_redirect=1 during cycle N+1 only, o_redirect_pc=i_target with bit0 cleared (held until next redirect).
REQ-024 o_flush SHALL be 1 for exactly FLUSH_CYCLES cycles starting cycle N+1, then state returns to IDLE.
REQ-025 Flush countdown SHALL advance every cycle regardless of i_stall.
REQ-026 In FLUSH, i_valid SHALL be ignored; no accept, no counter increment.
REQ-027 Accepted not-taken instruction SHALL cause no redirect, no flush, state stays IDLE.
REQ-028 o_busy SHALL equal (state==FLUSH).

Reset
REQ-029 On i_rst at an edge: state IDLE, o_redirect 0, o_flush 0, o_busy 0, o_redirect_pc 0x00000000, both counters 0.
REQ-030 Reset during FLUSH SHALL abort the flush; outputs read reset values the next cycle.
REQ-031 i_rst SHALL override a simultaneous accept.

Configuration
REQ-032 Macro BRU_PERF_CNT_EN SHALL gate the counters.
REQ-033 Defined: o_br_cnt +1 per accepted i_is_branch (jump precedence excluded), o_taken_cnt +1 per accepted taken instruction; both wrap 0xFFFF->0x0000.
REQ-034 Undefined: no counter flops; o_br_cnt and o_taken_cnt tied 0.

Verification
REQ-035 BEQ rs1=rs2=0x5, target 0x100 -> cycle N+1 o_redirect=1, o_redirect_pc=0x100; o_flush high 2 cycles; o_busy 2 cycles.
REQ-036 BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, no flush, o_br_un=1.
REQ-037 JAL with i_is_branch=1, BNE equal operands, target 0x203 -> taken, o_redirect_pc=0x202.
REQ-038 Taken BGE with i_stall=1 for 3 cycles -> no redirect until first edge with i_stall=0; second branch valid during FLUSH -> ignored.
REQ-039 i_rst asserted in first FLUSH cycle -> next cycle o_flush=0, o_busy=0, counters 0.
REQ-040 With BRU_PERF_CNT_EN, o_br_cnt preset to 0xFFFF via 65535 accepted branches, one more -> 0x0000; without macro counters stay 0.
